lcd_char_writer: RTL and testbench
==================================

Name: lcd_char_writer

Overview:
- Consumes 8-bit ASCII character codes from the switch/operator decode logic and drives an HD44780-compatible 2x16 character LCD over its 8-bit parallel bus.
- Performs power-up initialisation, per-character write cycles with E-strobe timing, cursor tracking with line wrap, and a clear/home command.
- Sits between the operator/digit decode logic and the board LCD pins.

Parameters:
- T_PWRUP, 20000, clk cycles waited after reset release before the first init command.
- T_SETUP, 2, clk cycles RS/DATA are stable before E rises.
- T_E, 10, clk cycles E is held high.
- T_CMD, 50, clk cycles of post-strobe wait for character writes and normal commands.
- T_CLR, 2000, clk cycles of post-strobe wait after the clear command 0x01.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset; rst=0 resets the block.
- i_char  in  8  character code to display.
- i_valid  in  1  i_char is valid.
- i_clear  in  1  request: clear the display and home the cursor.
- o_ready  out  1  block can accept a char or clear this cycle.
- o_col  out  4  current cursor column, 0..15.
- o_line  out  1  current cursor line, 0 or 1.
- lcd_e  out  1  LCD enable strobe.
- lcd_rs  out  1  LCD register select: 0 = command, 1 = data.
- lcd_rw  out  1  LCD read/write; tied to 0 (write only).
- lcd_data  out  8  LCD data bus.

Behaviour:
- Reset (rst=0, asynchronous):
  - lcd_e=0, lcd_rs=0, lcd_rw=0, lcd_data=0x00.
  - o_ready=0, o_col=0, o_line=0.
  - FSM goes to PWRUP. Any in-flight write is abandoned and E drops immediately.
- States: PWRUP, INIT, IDLE, SETUP, STROBE, WAIT.
- PWRUP:
  - Count T_PWRUP cycles, then enter INIT.
- INIT:
  - Issue command sequence 0x38, 0x0C, 0x06, 0x01, in that order, each as one bus cycle with rs=0.
  - 0x01 uses T_CLR as its wait; the others use T_CMD.
  - After the last command: o_col=0, o_line=0, go to IDLE.
- Bus cycle:
  - SETUP: drive rs/data, hold for T_SETUP cycles.
  - STROBE: lcd_e=1 for exactly T_E cycles.
  - WAIT: lcd_e=0, hold for T_CMD or T_CLR cycles.
  - lcd_data and lcd_rs stay stable from SETUP through the end of WAIT.
- IDLE:
  - o_ready=1 only in IDLE; it is a registered output.
  - Accept clear: i_clear & o_ready. Issue 0x01 (rs=0, T_CLR), reset col/line to 0.
  - Accept char: i_valid & o_ready & ~i_clear. Issue i_char (rs=1, T_CMD).
  - If i_clear and i_valid are both high, clear wins and the char is not accepted; the source must hold it.
  - o_ready falls on the edge after acceptance.
- Latency: for a char write with no wrap, o_ready returns to 1 exactly T_SETUP+T_E+T_CMD+1 cycles after the accepting edge.
- Cursor:
  - o_col increments at the end of each char write.
  - At col 15 on line 0: o_col=0, o_line=1, and a follow-on address command 0xC0 (rs=0, T_CMD) is issued before returning to IDLE.
  - At col 15 on line 1: o_col=0, o_line=0, follow-on command 0x80.
  - No other scrolling; existing characters are overwritten.
- During PWRUP and INIT, i_valid and i_clear are ignored (o_ready=0).
- All counters are sized for the maximum parameter value; a parameter of 0 is illegal.

Test Plan:
- Init, with T_PWRUP=20, T_SETUP=2, T_E=3, T_CMD=5, T_CLR=10: release rst -> after 20 cycles, four E pulses carrying 0x38, 0x0C, 0x06, 0x01 with rs=0, each pulse 3 cycles wide -> o_ready=1, o_col=0, o_line=0.
- Single char 0x2B:
  - lcd_rs=1 and lcd_data=0x2B, stable 2 cycles before E rises.
  - E high 3 cycles.
  - o_ready low for 10 cycles, high on the 11th.
  - o_col=1 afterwards.
- Line wrap: 16 chars 0x30..0x3F -> after the 16th data cycle, one command cycle 0xC0 with rs=0 -> o_col=0, o_line=1. 16 more chars -> command 0x80, o_line=0.
- Clear: after 5 chars assert i_clear -> command 0x01, o_ready low for 2+3+10 cycles -> o_col=0, o_line=0.
- Simultaneous events: i_clear=1 and i_valid=1 with i_char=0x2D in IDLE -> only 0x01 is issued. Holding i_valid afterwards -> 0x2D is written next.
- Reset mid-operation: drive rst=0 while lcd_e=1 -> lcd_e=0 and o_ready=0 the same instant, without a clock edge. On release, the full init sequence is replayed.

Source files
------------

// File: rtl/lcd_char_writer.sv
// HD44780 2x16 character writer: power-up init, per-character E-strobe bus cycles, cursor tracking with line wrap, clear/home.
// Each accepted char/clear costs T_SETUP+T_E+wait cycles of bus time; o_ready is low for the whole bus activity.
module lcd_char_writer #(
  parameter int T_PWRUP = 20000,
  parameter int T_SETUP = 2,
  parameter int T_E     = 10,
  parameter int T_CMD   = 50,
  parameter int T_CLR   = 2000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] i_char,
  input  logic       i_valid,
  input  logic       i_clear,
  output logic       o_ready,
  output logic [3:0] o_col,
  output logic       o_line,
  output logic       lcd_e,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic [7:0] lcd_data
);

  localparam int M_A   = (T_PWRUP > T_CLR) ? T_PWRUP : T_CLR;
  localparam int M_B   = (T_CMD > T_E) ? T_CMD : T_E;
  localparam int M_C   = (M_B > T_SETUP) ? M_B : T_SETUP;
  localparam int T_MAX = (M_A > M_C) ? M_A : M_C;
  localparam int CNT_W = $clog2(T_MAX + 1);

  typedef enum logic [2:0] {PWRUP, INIT, IDLE, SETUP, STROBE, WAIT} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       init_idx;
  logic             in_init;
  logic             is_clr;
  logic             wait_done;

  assign lcd_rw = 1'b0;

  // The clear command is the only one needing the long post-strobe wait.
  assign is_clr    = ~lcd_rs && (lcd_data == 8'h01);
  assign wait_done = is_clr ? (cnt == CNT_W'(T_CLR - 1)) : (cnt == CNT_W'(T_CMD - 1));

  function automatic logic [7:0] init_cmd(input logic [1:0] idx);
    case (idx)
      2'd0:    return 8'h38;
      2'd1:    return 8'h0C;
      2'd2:    return 8'h06;
      default: return 8'h01;
    endcase
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= PWRUP;
      cnt      <= '0;
      init_idx <= '0;
      in_init  <= 1'b1;
      o_ready  <= 1'b0;
      o_col    <= '0;
      o_line   <= 1'b0;
      lcd_e    <= 1'b0;
      lcd_rs   <= 1'b0;
      lcd_data <= '0;
    end else begin
      case (state)
        PWRUP: begin
          if (cnt == CNT_W'(T_PWRUP - 1)) begin
            cnt   <= '0;
            state <= INIT;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        INIT: begin
          if (init_idx == 3'd4) begin
            in_init <= 1'b0;
            o_col   <= '0;
            o_line  <= 1'b0;
            o_ready <= 1'b1;
            state   <= IDLE;
          end else begin
            lcd_rs   <= 1'b0;
            lcd_data <= init_cmd(init_idx[1:0]);
            init_idx <= init_idx + 1'b1;
            cnt      <= '0;
            state    <= SETUP;
          end
        end
        IDLE: begin
          // Clear has priority; a simultaneous char stays pending at the source.
          if (i_clear) begin
            o_ready  <= 1'b0;
            lcd_rs   <= 1'b0;
            lcd_data <= 8'h01;
            o_col    <= '0;
            o_line   <= 1'b0;
            cnt      <= '0;
            state    <= SETUP;
          end else if (i_valid) begin
            o_ready  <= 1'b0;
            lcd_rs   <= 1'b1;
            lcd_data <= i_char;
            cnt      <= '0;
            state    <= SETUP;
          end
        end
        SETUP: begin
          if (cnt == CNT_W'(T_SETUP - 1)) begin
            cnt   <= '0;
            lcd_e <= 1'b1;
            state <= STROBE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        STROBE: begin
          if (cnt == CNT_W'(T_E - 1)) begin
            cnt   <= '0;
            lcd_e <= 1'b0;
            state <= WAIT;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        WAIT: begin
          if (wait_done) begin
            cnt <= '0;
            if (in_init) begin
              state <= INIT;
            end else if (lcd_rs && (o_col == 4'd15)) begin
              // Wrap: move to the other line and re-address the controller's DDRAM pointer.
              o_col    <= '0;
              o_line   <= ~o_line;
              lcd_rs   <= 1'b0;
              lcd_data <= o_line ? 8'h80 : 8'hC0;
              state    <= SETUP;
            end else begin
              if (lcd_rs) o_col <= o_col + 1'b1;
              o_ready <= 1'b1;
              state   <= IDLE;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= PWRUP;
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_char_writer.sv
// Directed bench for lcd_char_writer: a bus monitor checks every strobe against a queue of expected LCD words and the cursor against a model.
module tb_lcd_char_writer;
  localparam int T_PWRUP = 20;
  localparam int T_SETUP = 2;
  localparam int T_E     = 3;
  localparam int T_CMD   = 5;
  localparam int T_CLR   = 10;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] i_char = 8'h00;
  logic       i_valid = 1'b0;
  logic       i_clear = 1'b0;
  logic       o_ready;
  logic [3:0] o_col;
  logic       o_line;
  logic       lcd_e, lcd_rs, lcd_rw;
  logic [7:0] lcd_data;

  int checks = 0;
  int passed = 0;

  // Expected LCD bus words in issue order, {rs, data}.
  logic [8:0] exp_q[$];
  int         m_col  = 0;
  int         m_line = 0;

  lcd_char_writer #(
    .T_PWRUP(T_PWRUP), .T_SETUP(T_SETUP), .T_E(T_E), .T_CMD(T_CMD), .T_CLR(T_CLR)
  ) dut (
    .clk(clk), .rst(rst), .i_char(i_char), .i_valid(i_valid), .i_clear(i_clear),
    .o_ready(o_ready), .o_col(o_col), .o_line(o_line),
    .lcd_e(lcd_e), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_data(lcd_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act == req) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
  endtask

  task automatic timeout(input string name);
    checks++;
    $display("FAIL %s: timed out at %0t", name, $time);
  endtask

  function automatic void model_reset();
    exp_q.delete();
    m_col  = 0;
    m_line = 0;
    exp_q.push_back({1'b0, 8'h38});
    exp_q.push_back({1'b0, 8'h0C});
    exp_q.push_back({1'b0, 8'h06});
    exp_q.push_back({1'b0, 8'h01});
  endfunction

  function automatic void model_accept(input bit clr, input bit v, input logic [7:0] c);
    if (clr) begin
      exp_q.push_back({1'b0, 8'h01});
      m_col  = 0;
      m_line = 0;
    end else if (v) begin
      exp_q.push_back({1'b1, c});
      if (m_col == 15) begin
        m_col  = 0;
        m_line = 1 - m_line;
        exp_q.push_back({1'b0, (m_line == 1) ? 8'hC0 : 8'h80});
      end else begin
        m_col++;
      end
    end
  endfunction

  // Bus monitor / compare process.
  logic [8:0] sig, prev_sig, exp_w;
  logic       prev_e = 1'b0;
  int         stable = 0, e_width = 0, since_fall = 1000;

  always @(negedge clk) begin
    sig = {lcd_rs, lcd_data};
    if (!rst) begin
      prev_e     = 1'b0;
      stable     = 0;
      e_width    = 0;
      since_fall = 1000;
      prev_sig   = sig;
    end else begin
      check("lcd_rw", int'(lcd_rw), 0);
      if (lcd_e && !prev_e) begin
        check("setup_stable", int'(stable >= T_SETUP && sig == prev_sig), 1);
        if (exp_q.size() == 0) begin
          checks++;
          $display("FAIL unexpected_strobe: got 0x%0h, expected no strobe at %0t", sig, $time);
        end else begin
          exp_w = exp_q.pop_front();
          check("bus_word", int'(sig), int'(exp_w));
        end
        e_width = 1;
      end else if (lcd_e) begin
        check("e_high_stable", int'(sig), int'(prev_sig));
        e_width++;
      end else if (prev_e) begin
        check("e_width", e_width, T_E);
        since_fall = 0;
      end else begin
        since_fall++;
      end
      if (!lcd_e && since_fall < T_CMD) check("wait_stable", int'(sig), int'(prev_sig));
      if (o_ready) begin
        check("o_col", int'(o_col), m_col);
        check("o_line", int'(o_line), m_line);
        check("queue_drained", exp_q.size(), 0);
      end
      if (sig == prev_sig) stable++;
      else stable = 1;
      prev_sig = sig;
      prev_e   = lcd_e;
    end
  end

  task automatic wait_ready();
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if (o_ready) return;
    end
    timeout("wait_ready");
  endtask

  task automatic accept(input bit clr, input bit v, input logic [7:0] c, input bit hold_valid);
    wait_ready();
    i_clear = clr;
    i_valid = v;
    i_char  = c;
    @(posedge clk);
    #1;
    model_accept(clr, v, c);
    i_clear = 1'b0;
    if (!hold_valid) i_valid = 1'b0;
  endtask

  task automatic measure_low(output int n);
    n = 0;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if (o_ready) return;
      n++;
    end
    timeout("measure_low");
  endtask

  int n;

  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_o_ready", int'(o_ready), 0);
    check("rst_lcd_e", int'(lcd_e), 0);
    check("rst_lcd_data", int'(lcd_data), 0);
    check("rst_cursor", int'({o_line, o_col}), 0);

    // Release reset with junk requests that must be ignored during power-up/init.
    rst     = 1'b1;
    i_valid = 1'b1;
    i_clear = 1'b1;
    i_char  = 8'h41;
    n = 0;
    begin : find_rise
      for (int i = 0; i < 200; i++) begin
        @(negedge clk);
        n++;
        if (lcd_e) disable find_rise;
      end
      timeout("first_strobe");
    end
    check("pwrup_delay_ok", int'(n >= T_PWRUP + T_SETUP && n <= T_PWRUP + T_SETUP + 2), 1);
    repeat (5) @(negedge clk);
    i_valid = 1'b0;
    i_clear = 1'b0;
    wait_ready();
    check("init_ready", int'(o_ready), 1);
    check("init_col", int'(o_col), 0);
    check("init_line", int'(o_line), 0);

    // Single char: ready low T_SETUP+T_E+T_CMD = 10 cycles, cursor advances.
    accept(1'b0, 1'b1, 8'h2B, 1'b0);
    measure_low(n);
    check("char_ready_low", n, 10);
    check("char_col", int'(o_col), 1);

    // Clear after 5 chars: ready low 2+3+10 = 15 cycles, cursor homed.
    for (int i = 0; i < 4; i++) accept(1'b0, 1'b1, 8'h61 + 8'(i), 1'b0);
    wait_ready();
    check("five_col", int'(o_col), 5);
    accept(1'b1, 1'b0, 8'h00, 1'b0);
    measure_low(n);
    check("clear_ready_low", n, 15);
    check("clear_cursor", int'({o_line, o_col}), 0);

    // Line wrap both ways.
    for (int i = 0; i < 16; i++) accept(1'b0, 1'b1, 8'h30 + 8'(i), 1'b0);
    wait_ready();
    check("wrap1_line", int'(o_line), 1);
    check("wrap1_col", int'(o_col), 0);
    for (int i = 0; i < 16; i++) accept(1'b0, 1'b1, 8'h30 + 8'(i), 1'b0);
    wait_ready();
    check("wrap0_line", int'(o_line), 0);
    check("wrap0_col", int'(o_col), 0);

    // Clear and char together: only the clear goes out; the held char follows.
    accept(1'b0, 1'b1, 8'h45, 1'b0);
    accept(1'b1, 1'b1, 8'h2D, 1'b1);
    accept(1'b0, 1'b1, 8'h2D, 1'b0);
    wait_ready();
    check("simul_col", int'(o_col), 1);

    // Reset during the strobe: E and ready drop without a clock edge, init replays.
    accept(1'b0, 1'b1, 8'h52, 1'b0);
    begin : find_e
      for (int i = 0; i < 100; i++) begin
        @(negedge clk);
        if (lcd_e) disable find_e;
      end
      timeout("mid_strobe");
    end
    #2 rst = 1'b0;
    #1;
    check("async_rst_e", int'(lcd_e), 0);
    check("async_rst_ready", int'(o_ready), 0);
    model_reset();
    repeat (3) @(negedge clk);
    rst = 1'b1;
    wait_ready();
    check("reinit_cursor", int'({o_line, o_col}), 0);
    check("reinit_queue", exp_q.size(), 0);
    accept(1'b0, 1'b1, 8'h5A, 1'b0);
    wait_ready();
    check("post_reset_col", int'(o_col), 1);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
